// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: hex glyph table (bits a..g), segment bit
// positions within the {a,b,c,d,e,f,g,dp} bus, and the scan state enum.
package seg_pkg;

    localparam int SEG_DP = 0;
    localparam int SEG_G  = 1;
    localparam int SEG_A  = 7;

    // Index = nibble value; bit 6 = a ... bit 0 = g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble -> {a..g,dp} pattern. blank darkens a..g only, so a
// caller can still show the decimal point on a suppressed digit.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = 8'h00;
        if (!blank) begin
            pattern[SEG_A:SEG_G] = HEX_SEG[nibble];
        end
        pattern[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with frame snapshot, LZB, masks and an
// anti-ghosting gap. Define SEG_DIM_EN to add the dim port and PWM window.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int DIV      = 1000,
    parameter int GAP      = 2,
    parameter int DIM_BITS = 3
) (
    input  logic                  seg_clock,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lzb_en,
`ifdef SEG_DIM_EN
    input  logic [DIM_BITS-1:0]   dim,
`endif
    output logic [7:0]            seg_output,
    output logic [DIGITS-1:0]     cat_output,
    output logic                  frame_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DIDX_MAX = DW'(DIGITS - 1);
`ifndef SEG_DIM_EN
    localparam int WIN_FULL = GAP + (((DIV - GAP) * (1 << DIM_BITS)) >> DIM_BITS);
`endif

    scan_state_e           state_q, state_d;
    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [DW-1:0]         didx_q, didx_d;
    logic [4*DIGITS-1:0]   data_sh_q, data_sh_d;
    logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]     blank_sh_q, blank_sh_d;
    logic [DIGITS-1:0]     lzb_sh_q, lzb_sh_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     cat_q, cat_d;
    logic                  fs_q, fs_d;
`ifdef SEG_DIM_EN
    logic [DIM_BITS-1:0]   dim_q, dim_d;
`endif

    logic                  slot_tick;
    logic                  snap;
    logic                  lit;
    logic                  still_zero;
    logic [DIGITS-1:0]     lzb_now;
    int                    win_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [7:0]            cur_pat;

    assign slot_tick = (pcnt_q == PCNT_MAX);

    // Leading-zero mask from the live inputs; only latched at snapshot time.
    always_comb begin
        lzb_now    = '0;
        still_zero = lzb_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digit_data[4*i +: 4] != 4'h0) begin
                still_zero = 1'b0;
            end
            lzb_now[i] = still_zero;
        end
    end

    // Everything below is evaluated on the *next* slot/digit so that seg and
    // cat register together and never trail the scan position.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = slot_tick ? '0 : pcnt_q + 1'b1;
        didx_d     = didx_q;
        data_sh_d  = data_sh_q;
        dp_sh_d    = dp_sh_q;
        blank_sh_d = blank_sh_q;
        lzb_sh_d   = lzb_sh_q;

        if (slot_tick) begin
            if (state_q == IDLE) begin
                state_d = SCAN;
                didx_d  = '0;
            end else begin
                didx_d = (didx_q == DIDX_MAX) ? '0 : didx_q + 1'b1;
            end
        end

        snap = slot_tick && (didx_d == '0);
        if (snap) begin
            data_sh_d  = digit_data;
            dp_sh_d    = dp_mask;
            blank_sh_d = blank_mask;
            lzb_sh_d   = lzb_now;
        end
    end

`ifdef SEG_DIM_EN
    always_comb begin
        dim_d   = slot_tick ? dim : dim_q;
        win_end = GAP + (((DIV - GAP) * (int'(dim_d) + 1)) >> DIM_BITS);
    end
`else
    assign win_end = WIN_FULL;
`endif

    assign cur_nib   = data_sh_d[4*didx_d +: 4];
    assign cur_dp    = dp_sh_d[didx_d] & ~blank_sh_d[didx_d];
    assign cur_blank = lzb_sh_d[didx_d] | blank_sh_d[didx_d];

    seg_hex_decode u_dec (
        .nibble  (cur_nib),
        .dp      (cur_dp),
        .blank   (cur_blank),
        .pattern (cur_pat)
    );

    always_comb begin
        lit = (state_d == SCAN) && (int'(pcnt_d) >= GAP) && (int'(pcnt_d) < win_end)
              && !blank_sh_d[didx_d];
        seg_d = (state_d == SCAN) ? cur_pat : 8'h00;
        cat_d = lit ? ~(DIGITS'(1) << didx_d) : '1;
        fs_d  = snap;
    end

    always_ff @(posedge seg_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            didx_q     <= '0;
            data_sh_q  <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            lzb_sh_q   <= '0;
            seg_q      <= 8'h00;
            cat_q      <= '1;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            didx_q     <= didx_d;
            data_sh_q  <= data_sh_d;
            dp_sh_q    <= dp_sh_d;
            blank_sh_q <= blank_sh_d;
            lzb_sh_q   <= lzb_sh_d;
            seg_q      <= seg_d;
            cat_q      <= cat_d;
            fs_q       <= fs_d;
        end
    end

`ifdef SEG_DIM_EN
    always_ff @(posedge seg_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dim_q <= '0;
        end else begin
            dim_q <= dim_d;
        end
    end
`endif

    assign seg_output  = seg_q;
    assign cat_output  = cat_q;
    assign frame_start = fs_q;

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised time-multiplexed 7-segment scanner for the DDS front panel, successor to the fixed 8-digit display driver. It takes DIGITS packed hex nibbles and decodes one digit per scan slot onto a shared segment bus, using active-low one-hot digit cathodes. It adds what the fixed driver lacks:
- frame-coherent input snapshot
- per-digit decimal-point and blank masks
- optional leading-zero blanking
- an anti-ghosting gap between slots
- optional brightness PWM
- matched seg/cat timing, with no one-slot lag

## Interface
- DIGITS, 8 — number of digits; 2..16
- DIV, 1000 — seg_clock cycles per digit slot; DIV ≥ GAP+2
- GAP, 2 — cycles at the start of each slot with all cathodes off (anti-ghosting)
- DIM_BITS, 3 — brightness resolution (used only with SEG_DIM_EN)
- seg_clock  in  1  — scan clock; single clock domain
- sys_rst_n  in  1  — asynchronous, active-low reset
- digit_data  in  4*DIGITS  — nibble i at [4i+3:4i]; digit 0 is rightmost/least significant
- dp_mask  in  DIGITS  — 1 = light the DP of digit i
- blank_mask  in  DIGITS  — 1 = digit i fully dark (segments and DP)
- lzb_en  in  1  — 1 = suppress leading zeros
- dim  in  DIM_BITS  — brightness, 0 = dimmest, all-ones = full (port present only with SEG_DIM_EN)
- seg_output  out  8  — {a,b,c,d,e,f,g,dp}, active-high
- cat_output  out  DIGITS  — active-low one-hot digit select
- frame_start  out  1  — one-cycle pulse marking the start of a new frame

## Operation
- **Prescaler**
  - `pcnt` counts 0..DIV-1 and wraps.
  - `slot_tick` is asserted when pcnt == DIV-1.
  - `didx` counts 0..DIGITS-1 and wraps to 0, advancing on slot_tick.
- **States**
  - IDLE (after reset): outputs dark.
  - On the first slot_tick, IDLE → SCAN with didx = 0.
  - SCAN is left only by reset.
- **Snapshot**
  - On every slot_tick that enters didx = 0, digit_data, dp_mask, blank_mask and lzb_en are latched into shadow registers.
  - Mid-frame input changes do not appear until the next frame.
- **Leading-zero blanking**
  - Computed from the shadow data at snapshot time.
  - When lzb_en = 1, digits DIGITS-1 downward are blanked while their nibble is 0, stopping at the first non-zero nibble.
  - Digit 0 is never LZB-blanked.
  - DP on an LZB-blanked digit is still shown if its dp_mask bit is set.
  - blank_mask overrides everything.
- **Decode (hex, bits a..g)**
  - 0: FC, 1: 60, 2: DA, 3: F2, 4: 66, 5: B6, 6: BE, 7: E0
  - 8: FE, 9: F6, A: EE, b: 3E, C: 9C, d: 7A, E: 9E, F: 8E
  - seg[0] = dp bit.
- **Cathode**
  - cat_output = ~(1 << didx) while lit; all ones otherwise.
- **Lit window within a slot**
  - Base: pcnt ≥ GAP.
  - With SEG_DIM_EN, additionally pcnt < GAP + (((DIV-GAP)*(dim+1)) >> DIM_BITS).
  - dim is sampled at each slot start.
- Segments for a dark slot are driven to 8'h00.

## Timing
- **Reset:** seg_output = 8'h00, cat_output = all ones, frame_start = 0, pcnt = 0, didx = 0, shadows = 0, state IDLE.
- **Registered outputs:** all outputs are registered. seg_output and cat_output update on the same seg_clock edge, so they never show a neighbouring digit's pattern.
- **Slot entry:**
  - Cycle 0 of every slot: cat all ones; seg already holds the new digit's pattern.
  - Cathode asserts at cycle GAP of the slot.
  - With full brightness, cathode deasserts at the slot_tick edge.
- **frame_start:** high for exactly the first cycle of each digit-0 slot, i.e. the cycle after the snapshot edge.
- **First frame:** it begins DIV cycles after reset release; the first lit cathode appears DIV+GAP cycles after release.
- **Reset mid-slot:** all outputs dark on the next evaluation of async reset; no partial slot is completed.
- **Input hold:** inputs have no handshake; sampled only at frame start (dim at slot start).

## Configuration
- **SEG_DIM_EN defined:** dim port and PWM lit-window logic are present.
- **SEG_DIM_EN undefined:** no dim port; each digit is lit from cycle GAP to the end of its slot; behaviour is identical to dim = all-ones.

## Structure
- The shared package `seg_pkg` holds:
  - the 16-entry hex-to-segment constant table (bits a..g)
  - segment bit-index constants (SEG_DP = 0)
  - the scan state enum {IDLE, SCAN}
- One sub-module, `seg_hex_decode`: combinational nibble+dp+blank → 8-bit pattern, reused by other panel blocks.
- Prescaler, snapshot/LZB logic and cathode control stay in `seg_scan_mux`.

## Test plan
- **Reset/first frame:** DIGITS = 4, DIV = 8, GAP = 2, deassert sys_rst_n.
  - Outputs are 00 / 1111 for 8 cycles.
  - frame_start pulses at cycle 8.
  - cat = 1110 from cycle 10.
- **Decode sweep:** digit_data = 16'hA5C0, dp_mask = 4'b0010, lzb_en = 0.
  - Digit 0 → FC, digit 1 → 9D, digit 2 → B6, digit 3 → EE.
  - Each appears with the matching cat and seg never lags cat.
- **Snapshot coherency:** change digit_data from 16'h1234 to 16'h5678 during the digit-2 slot.
  - The rest of that frame shows 1234.
  - The next frame shows 5678.
- **Leading-zero blanking:** digit_data = 16'h0040, lzb_en = 1.
  - Digits 3 and 2 → seg 00 with cat still scanning.
  - Digit 1 → 66, digit 0 → FC.
  - With 16'h0000, only digit 0 shows FC.
- **Blank/DP masks:** blank_mask = 4'b0100 with dp_mask = 4'b0100.
  - Digit 2 → seg 00 and cat stays all ones for its whole slot.
- **Dim (SEG_DIM_EN):** DIV = 34, GAP = 2, DIM_BITS = 3, dim = 1.
  - Cathode low for 8 cycles per slot (cycles 2..9).
  - With dim = 7, low for 32 cycles.
  - Assert reset mid-window → cat all ones immediately.
